// File: rtl/product_disp_driver_if.sv
// product_disp_driver_if
//   Load/status/display bundle for the product display driver.
//   master : the producer side (drives load/value, watches busy, an, seg)
//   slave  : the driver itself
//   Signals:
//     load  - one-cycle capture/start pulse
//     value - 8-bit unsigned product
//     busy  - conversion in progress
//     an    - digit enables, active-low, bit0 = rightmost digit
//     seg   - segments a..g on bits 0..6, dp on bit 7, all active-low
interface product_disp_driver_if;
  logic       load;
  logic [7:0] value;
  logic       busy;
  logic [7:0] an;
  logic [7:0] seg;

  modport master (output load, value, input  busy, an, seg);
  modport slave  (input  load, value, output busy, an, seg);
endinterface

// File: rtl/product_disp_driver.sv
// product_disp_driver
//   Takes an 8-bit product, converts it to three BCD digits with a
//   one-shift-per-clock double-dabble engine, and scans the digits onto an
//   active-low 7-segment display (three digit slots out of eight).
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - product_disp_driver_if.slave (load, value, busy, an, seg)
//   Parameters:
//     SCAN_DIV - clocks each digit stays lit (>= 2)
//     CNT_W    - refresh counter width, 2**CNT_W >= SCAN_DIV
//   Build option:
//     LEAD_ZERO_BLANK_EN - blank a zero hundreds digit, and a zero tens
//                          digit when hundreds is also zero.

// Per-digit decoder; nibbles above 9 and blanked digits drive all-off.
module product_disp_seg7 (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg = 8'hFF;
    if (!blank) begin
      case (digit)
        4'd0: seg = 8'hC0;
        4'd1: seg = 8'hF9;
        4'd2: seg = 8'hA4;
        4'd3: seg = 8'hB0;
        4'd4: seg = 8'h99;
        4'd5: seg = 8'h92;
        4'd6: seg = 8'h82;
        4'd7: seg = 8'hF8;
        4'd8: seg = 8'h80;
        4'd9: seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end
endmodule

module product_disp_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  product_disp_driver_if.slave bus
);
  localparam int NUM_DIG = 3;

  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nxt;

  logic [7:0]              bin_q;
  logic [NUM_DIG*4-1:0]    bcd_q;    // working BCD {hundreds, tens, ones}
  logic [NUM_DIG*4-1:0]    disp_q;   // displayed BCD, updated only on completion
  logic [2:0]              cnt_q;
  logic [NUM_DIG*4-1:0]    bcd_adj;
  logic [NUM_DIG*4-1:0]    bcd_sh;
  logic [7:0]              bin_sh;
  logic                    last;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // 8 shifts: count 0..7, the shift at count 7 is the final one.
  assign last = (cnt_q == 3'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.load) state_nxt = CONV;
      CONV: if (last)     state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == CONV);

  // add-3 on every nibble >= 5, then shift {bcd, bin} left by one
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
  end
  assign bcd_sh = {bcd_adj[NUM_DIG*4-2:0], bin_q[7]};
  assign bin_sh = {bin_q[6:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
    end else if (state == IDLE) begin
      if (bus.load) begin
        bin_q <= bus.value;
        bcd_q <= '0;
        cnt_q <= '0;
      end
    end else begin
      bin_q <= bin_sh;
      bcd_q <= bcd_sh;
      cnt_q <= cnt_q + 3'd1;
      // final shift result goes straight to the display, skipping a cycle
      if (last) disp_q <= bcd_sh;
    end
  end

  // ---------------- refresh scanner ----------------
  logic [CNT_W-1:0] rcnt_q;
  logic [1:0]       idx_q;
  logic             wrap;

  assign wrap = (rcnt_q == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (wrap) begin
      rcnt_q <= '0;
      idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      rcnt_q <= rcnt_q + CNT_W'(1);
    end
  end

  // ---------------- digit decode ----------------
  logic [NUM_DIG-1:0]        blank;
  logic [NUM_DIG-1:0][7:0]   dig_seg;

`ifdef LEAD_ZERO_BLANK_EN
  assign blank[0] = 1'b0;
  assign blank[1] = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
  assign blank[2] = (disp_q[11:8] == 4'd0);
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    product_disp_seg7 u_seg7 (
      .digit (disp_q[4*i +: 4]),
      .blank (blank[i]),
      .seg   (dig_seg[i])
    );
  end

  // ---------------- registered outputs ----------------
  logic [7:0] an_d, seg_d, an_q, seg_q;

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    case (idx_q)
      2'd0: begin an_d = 8'hFE; seg_d = dig_seg[0]; end
      2'd1: begin an_d = 8'hFD; seg_d = dig_seg[1]; end
      2'd2: begin an_d = 8'hFB; seg_d = dig_seg[2]; end
      default: begin an_d = 8'hFF; seg_d = 8'hFF; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
endmodule

// File: tb/tb_product_disp_driver.sv
// tb_product_disp_driver
//   Directed bench for product_disp_driver built with SCAN_DIV=4.
//   Honours LEAD_ZERO_BLANK_EN when computing expected segment codes.
module tb_product_disp_driver;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  product_disp_driver_if bus ();

  product_disp_driver #(.SCAN_DIV(SD), .CNT_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] code(input logic [3:0] d);
    case (d)
      4'd0: code = 8'hC0; 4'd1: code = 8'hF9; 4'd2: code = 8'hA4;
      4'd3: code = 8'hB0; 4'd4: code = 8'h99; 4'd5: code = 8'h92;
      4'd6: code = 8'h82; 4'd7: code = 8'hF8; 4'd8: code = 8'h80;
      4'd9: code = 8'h90; default: code = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_h(input logic [3:0] h);
`ifdef LEAD_ZERO_BLANK_EN
    exp_h = (h == 4'd0) ? 8'hFF : code(h);
`else
    exp_h = code(h);
`endif
  endfunction

  function automatic logic [7:0] exp_t(input logic [3:0] h, input logic [3:0] t);
`ifdef LEAD_ZERO_BLANK_EN
    exp_t = (h == 4'd0 && t == 4'd0) ? 8'hFF : code(t);
`else
    exp_t = code(t);
`endif
  endfunction

  function automatic logic [7:0] exp_for_an(input logic [7:0] an, input logic [3:0] h,
                                            input logic [3:0] t, input logic [3:0] o);
    case (an)
      8'hFE:   exp_for_an = code(o);
      8'hFD:   exp_for_an = exp_t(h, t);
      8'hFB:   exp_for_an = exp_h(h);
      default: exp_for_an = 8'hFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse load and follow the conversion: returns busy length and how many
  // busy cycles showed something other than the old digits.
  task automatic run_conv(input logic [7:0] v, input logic [3:0] oh, input logic [3:0] ot,
                          input logic [3:0] oo, output int nbusy, output int nbad);
    bus.load = 1'b1; bus.value = v;
    tick();
    bus.load = 1'b0;
    nbusy = 0; nbad = 0;
    while (bus.busy && nbusy < 20) begin
      nbusy++;
      if (bus.seg !== exp_for_an(bus.an, oh, ot, oo)) nbad++;
      tick();
    end
  endtask

  // Watch the scan long enough to see all three slots.
  task automatic scan(output logic [7:0] so, output logic [7:0] st, output logic [7:0] sh);
    so = 8'h00; st = 8'h00; sh = 8'h00;
    for (int i = 0; i < 3*SD + 2; i++) begin
      case (bus.an)
        8'hFE: so = bus.seg;
        8'hFD: st = bus.seg;
        8'hFB: sh = bus.seg;
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.value = 8'd0; rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.load = ~bus.load; bus.value = 8'd99;
      nchk++;
      if (bus.busy !== 1'b0 || bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
        nfail++;
        $display("FAIL reset_hold: busy=%b an=%h seg=%h want busy=0 an=FF seg=FF",
                 bus.busy, bus.an, bus.seg);
      end
    end
    bus.load = 1'b0;
    rst_n = 1'b1;
    tick();
    nchk++;
    if (bus.an !== 8'hFE || bus.seg !== 8'hC0) begin
      nfail++;
      $display("FAIL reset_release: an=%h seg=%h want an=FE seg=C0", bus.an, bus.seg);
    end
  endtask

  task automatic test_conv30();
    int nb, nbad; logic [7:0] so, st, sh;
    run_conv(8'd30, 4'd0, 4'd0, 4'd0, nb, nbad);
    nchk++;
    if (nb !== 8) begin nfail++; $display("FAIL conv30_busy: got %0d cycles want 8", nb); end
    nchk++;
    if (nbad !== 0) begin nfail++; $display("FAIL conv30_hold: %0d partial cycles want 0", nbad); end
    scan(so, st, sh);
    nchk++;
    if (so !== 8'hC0 || st !== 8'hB0 || sh !== exp_h(4'd0)) begin
      nfail++;
      $display("FAIL conv30_digits: o=%h t=%h h=%h want o=C0 t=B0 h=%h", so, st, sh, exp_h(4'd0));
    end
  endtask

  task automatic test_max();
    int nb, nbad; logic [7:0] so, st, sh;
    run_conv(8'd255, 4'd0, 4'd3, 4'd0, nb, nbad);
    nchk++;
    if (nb !== 8) begin nfail++; $display("FAIL max_busy: got %0d cycles want 8", nb); end
    nchk++;
    if (nbad !== 0) begin nfail++; $display("FAIL max_hold: %0d partial cycles want 0", nbad); end
    scan(so, st, sh);
    nchk++;
    if (so !== 8'h92 || st !== 8'h92 || sh !== 8'hA4) begin
      nfail++;
      $display("FAIL max_digits: o=%h t=%h h=%h want o=92 t=92 h=A4", so, st, sh);
    end
  endtask

  task automatic test_load_while_busy();
    int n; logic [7:0] so, st, sh;
    bus.load = 1'b1; bus.value = 8'd225;
    tick();
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (n == 3) begin bus.load = 1'b1; bus.value = 8'd1; end
      else bus.load = 1'b0;
      tick();
    end
    bus.load = 1'b0;
    nchk++;
    if (n !== 8) begin nfail++; $display("FAIL lwb_busy: got %0d cycles want 8", n); end
    tick();
    nchk++;
    if (bus.busy !== 1'b0) begin nfail++; $display("FAIL lwb_restart: busy=%b want 0", bus.busy); end
    scan(so, st, sh);
    nchk++;
    if (so !== 8'h92 || st !== 8'hA4 || sh !== 8'hA4) begin
      nfail++;
      $display("FAIL lwb_digits: o=%h t=%h h=%h want o=92 t=A4 h=A4", so, st, sh);
    end
  endtask

  task automatic test_scan_wrap();
    int len, bad, w;
    logic [7:0] seq [4];
    seq[0] = 8'hFE; seq[1] = 8'hFD; seq[2] = 8'hFB; seq[3] = 8'hFE;
    w = 0;
    while (bus.an !== 8'hFB && w < 20) begin w++; tick(); end
    while (bus.an === 8'hFB && w < 40) begin w++; tick(); end
    nchk++;
    if (w >= 40 || bus.an !== 8'hFE) begin
      nfail++; $display("FAIL scan_sync: an=%h want FE after FB", bus.an);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      len = 0;
      while (bus.an === seq[k] && len < 10) begin
        if (bus.an[7:3] !== 5'h1F) bad++;
        len++;
        tick();
      end
      nchk++;
      if (len !== SD) begin
        nfail++; $display("FAIL scan_hold_%0d: an=%h held %0d want %0d", k, seq[k], len, SD);
      end
    end
    nchk++;
    if (bus.an !== seq[3]) begin nfail++; $display("FAIL scan_wrap: an=%h want FE", bus.an); end
    nchk++;
    if (bad !== 0) begin nfail++; $display("FAIL scan_upper: %0d cycles with an[7:3]!=1F", bad); end
  endtask

  task automatic test_back_to_back();
    int n; logic [7:0] so, st, sh;
    bus.load = 1'b1; bus.value = 8'd7;
    tick();
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      // raise load for the edge on which busy falls: must be ignored
      if (n == 8) begin bus.load = 1'b1; bus.value = 8'd9; end
      tick();
    end
    bus.load = 1'b0;
    nchk++;
    if (n !== 8) begin nfail++; $display("FAIL b2b_busy: got %0d cycles want 8", n); end
    tick();
    nchk++;
    if (bus.busy !== 1'b0) begin nfail++; $display("FAIL b2b_ignore: busy=%b want 0", bus.busy); end
    scan(so, st, sh);
    nchk++;
    if (so !== 8'hF8 || st !== exp_t(4'd0, 4'd0) || sh !== exp_h(4'd0)) begin
      nfail++;
      $display("FAIL b2b_digits: o=%h t=%h h=%h want o=F8 t=%h h=%h",
               so, st, sh, exp_t(4'd0, 4'd0), exp_h(4'd0));
    end
  endtask

  task automatic test_reset_mid();
    int n, late; logic [7:0] so, st, sh;
    bus.load = 1'b1; bus.value = 8'd200;
    tick();
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 4) begin n++; if (n < 4) tick(); end
    rst_n = 1'b0;
    tick();
    tick();
    nchk++;
    if (bus.busy !== 1'b0 || bus.an !== 8'hFF || bus.seg !== 8'hFF) begin
      nfail++;
      $display("FAIL rmid_reset: busy=%b an=%h seg=%h want 0/FF/FF", bus.busy, bus.an, bus.seg);
    end
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.busy !== 1'b0) late++; end
    nchk++;
    if (late !== 0) begin nfail++; $display("FAIL rmid_busy: busy seen %0d cycles want 0", late); end
    scan(so, st, sh);
    nchk++;
    if (so !== 8'hC0 || st !== exp_t(4'd0, 4'd0) || sh !== exp_h(4'd0)) begin
      nfail++;
      $display("FAIL rmid_digits: o=%h t=%h h=%h want o=C0 t=%h h=%h",
               so, st, sh, exp_t(4'd0, 4'd0), exp_h(4'd0));
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.value = 8'd0;
    test_reset();
    test_conv30();
    test_max();
    test_load_while_busy();
    test_scan_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/product_disp_driver.md
Name: product_disp_driver

Overview:
- Downstream display stage for the 4-bit multiplier datapath: consumes the 8-bit product and drives the board's 8-digit active-low 7-segment display.
- Converts the binary product (0..255) to three BCD digits with a sequential double-dabble engine, one shift per clock.
- Time-multiplexes the three digits onto the shared segment bus with a programmable refresh counter.

Parameters:
- SCAN_DIV, 50000: clocks each digit stays lit before the scanner advances; legal range ≥2.
- CNT_W, 16: refresh counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle pulse: capture value and start conversion.
- value  input  8  unsigned product from the multiplier.
- busy  output  1  high while conversion is in progress.
- an  output  8  digit enables, active-low, bit0 = rightmost digit.
- seg  output  8  segments, active-low; bit0..6 = a..g, bit7 = dp, which is always 1 (off).

Behaviour:
- Reset (async, rst_n=0):
  - busy=0; an=8'hFF; seg=8'hFF.
  - Stored BCD (hundreds/tens/ones) = 0; digit index = 0; refresh counter = 0; FSM = IDLE.
- FSM has two states: IDLE, CONV.
- IDLE + load=1:
  - capture value into the shift register and clear the working BCD.
  - shift count = 0; busy=1 from the next cycle; go to CONV.
- CONV, each clock:
  - add 3 to every working BCD nibble ≥5.
  - then shift {bcd, bin} left by 1; count++.
  - After the 8th shift: copy the working BCD into the displayed BCD in the same edge, busy=0, go to IDLE.
- Latency: busy is high for exactly 8 cycles; the displayed digits change on the 8th edge after the load edge.
- load while busy=1 is ignored; the in-flight conversion is unaffected.
- load on the same edge busy falls is ignored; it is accepted only when busy=0 is sampled.
- Displayed digits hold their old values throughout a conversion, with no partial values visible.
- Refresh counter:
  - counts 0..SCAN_DIV-1 and wraps to 0.
  - on wrap, digit index advances 0→1→2→0; index 3..7 is never reached.
- an/seg are registered from the digit index and displayed BCD, one cycle behind the index:
  - index 0 → an=8'hFE, ones digit.
  - index 1 → an=8'hFD, tens digit.
  - index 2 → an=8'hFB, hundreds digit.
  - an[7:3] stay 1 permanently.
- Segment codes (seg, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF.
  - Any BCD nibble >9 (not expected) displays blank.
- Reset mid-conversion: the conversion is aborted, the displayed BCD returns to 000, and no completion occurs after release.
- First clock after reset release: an=8'hFE, seg=8'hC0.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined:
  - hundreds digit shows FF (an still asserted for its slot) when hundreds=0.
  - tens digit shows FF when hundreds=0 and tens=0.
  - ones digit is never blanked.
- Undefined: all three digits always show their numeric code, including leading zeros.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with load toggling → busy=0, an=FF, seg=FF; one cycle after release → an=FE, seg=C0.
- Conversion of 30 (15×2): load with value=8'd30 → busy=1 for exactly 8 cycles. Scanning then shows:
  - ones: an=FE, seg=C0.
  - tens: an=FD, seg=B0.
  - hundreds: an=FB, seg=C0, or FF with LEAD_ZERO_BLANK_EN.
- Max value: load 8'd255 → digits 5/5/2 → seg 92, 92, A4 on FE, FD, FB.
- Load while busy: load 8'd225, then load 8'd1 three cycles later → the second load is ignored, the final display is 2/2/5, and busy is high for 8 cycles total.
- Scan wrap with SCAN_DIV=4: an sequence FE, FD, FB, FE, each held exactly 4 cycles; an[7:3] stay 1 throughout.
- Reset mid-conversion: load 8'd200, assert rst_n=0 at cycle 4 of busy → after release, display 000 (or blank/blank/0 with the macro) and busy=0 with no late update.
